// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: data-memory handshake, store lane steering, load extension
package mem_stage_pkg;
   localparam logic [6:0] op_load  = 7'b0000011;
   localparam logic [6:0] op_store = 7'b0100011;

   typedef struct packed {
      logic [6:0] opcode;
      logic       load_regfile;
      logic       write;
   } ctrl_regs;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      ctrl_regs    ctrl;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rs2;
   } stage_regs;
endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  stage_regs   in_regs,
   output logic        stall_out,
   output stage_regs   out_regs,
   output logic [31:0] out_rdata,
   output logic        misalign,
   output logic [31:0] dmem_addr,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_byte_enable,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp
);
   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nx;
   logic        is_load, is_store, mem_op, illegal, issue;
   logic [1:0]  off;
   logic [2:0]  f3;
   logic [4:0]  shamt;
   logic [31:0] rshift, load_data, store_data;
   logic [3:0]  store_be;
   stage_regs   suppressed;

   assign f3       = in_regs.funct3;
   assign off      = in_regs.alu[1:0];
   assign shamt    = {off, 3'b000};
   assign is_load  = in_regs.ctrl.opcode == op_load;
   assign is_store = in_regs.ctrl.opcode == op_store;
   assign mem_op   = in_regs.valid & (is_load | is_store);
   assign issue    = mem_op & ~illegal;

   always_comb begin
      illegal = 1'b0;
      if (is_load)
         illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111)
                 | ((f3[1:0] == 2'b01) & off[0])
                 | ((f3 == 3'b010) & (off != 2'b00));
      else if (is_store)
         illegal = (f3 >= 3'b011)
                 | ((f3 == 3'b001) & off[0])
                 | ((f3 == 3'b010) & (off != 2'b00));
   end

   // Halfword/byte lanes are selected by the low address bits, both ways.
   always_comb begin
      rshift     = dmem_rdata >> shamt;
      store_data = in_regs.rs2 << shamt;
      case (f3[1:0])
         2'b00:   store_be = 4'b0001 << off;
         2'b01:   store_be = 4'b0011 << off;
         default: store_be = 4'b1111;
      endcase
      case (f3)
         3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
         3'b100:  load_data = {24'h0, rshift[7:0]};
         3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
         3'b101:  load_data = {16'h0, rshift[15:0]};
         default: load_data = rshift;
      endcase
   end

   always_comb begin
      suppressed                   = in_regs;
      suppressed.ctrl.load_regfile = 1'b0;
      suppressed.ctrl.write        = 1'b0;
   end

   always_comb begin
      state_nx  = state;
      stall_out = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: if (issue) begin
               stall_out = 1'b1;
               state_nx  = WAIT;
            end
            WAIT: begin
               stall_out = ~dmem_resp;
               if (dmem_resp) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_regs         <= '0;
         out_rdata        <= '0;
         misalign         <= 1'b0;
         dmem_addr        <= '0;
         dmem_read        <= 1'b0;
         dmem_write       <= 1'b0;
         dmem_byte_enable <= '0;
         dmem_wdata       <= '0;
      end else if (state == IDLE) begin
         out_rdata <= '0;
         if (issue) begin
            out_regs         <= in_regs;
            out_regs.valid   <= 1'b0;
            misalign         <= 1'b0;
            dmem_addr        <= {in_regs.alu[31:2], 2'b00};
            dmem_read        <= is_load;
            dmem_write       <= is_store;
            dmem_byte_enable <= is_load ? 4'b1111 : store_be;
            dmem_wdata       <= is_store ? store_data : 32'h0;
         end else if (mem_op) begin
            out_regs <= suppressed;
            misalign <= 1'b1;
         end else begin
            out_regs <= in_regs;
            misalign <= 1'b0;
         end
      end else begin
         misalign <= 1'b0;
         // in_regs is still the held instruction, so it completes here.
         if (dmem_resp) begin
            out_regs         <= in_regs;
            out_rdata        <= is_load ? load_data : 32'h0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= '0;
         end
      end
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the five-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and it owns the data-memory handshake. Loads and stores are issued to data memory with byte enables and shifted write data. The upstream pipeline is stalled until memory responds. Load data is extracted, sign- or zero-extended, and registered together with the MEM/WB stage_regs. Non-memory instructions pass through with zero added latency.

Parameters:
none

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_regs  in  stage_regs  EX/MEM register contents (uses valid, ctrl.opcode, funct3, alu = effective address, rs2 = store data)
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
out_regs  out  stage_regs  MEM/WB register
out_rdata  out  32  extended load data, registered alongside out_regs
misalign  out  1  one-cycle registered pulse: instruction in out_regs was a suppressed misaligned or illegal access
dmem_addr  out  32  word-aligned address (alu & ~3), registered
dmem_read  out  1  registered read request
dmem_write  out  1  registered write request
dmem_byte_enable  out  4  registered byte mask
dmem_wdata  out  32  registered, lane-shifted store data
dmem_rdata  in  32  read word, valid with dmem_resp
dmem_resp  in  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; out_regs all zero (valid=0); out_rdata=0; misalign=0; dmem_read, dmem_write, dmem_byte_enable, dmem_addr, dmem_wdata all 0; stall_out=0 while rst is high.
- Memory-op condition: mem_op = in_regs.valid & (opcode==op_load | opcode==op_store).
- Offset: off = alu[1:0].
- Illegal condition: lh/lhu/sh with off[0]=1; lw/sw with off!=0; load funct3 in {011,110,111}; store funct3 >= 011.
- FSM states: IDLE, WAIT.
- IDLE, not mem_op (including bubbles):
  - stall_out=0.
  - At the clock edge: out_regs<=in_regs, out_rdata<=0, misalign<=0.
- IDLE, mem_op and illegal:
  - No request is issued; stall_out=0.
  - At the clock edge: out_regs<=in_regs with ctrl.load_regfile=0 and ctrl.write=0; misalign<=1; out_rdata<=0.
- IDLE, mem_op and legal:
  - stall_out=1 (combinational).
  - At the clock edge: register the request and go to WAIT. out_regs.valid<=0, so a bubble is presented to WB.
  - Load request: dmem_read=1, byte_enable=1111.
  - Store request:
    - dmem_write=1; byte_enable = sb 0001<<off, sh 0011<<off, sw 1111.
    - wdata = rs2 << (8*off).
- WAIT:
  - Request outputs are held stable; stall_out = ~dmem_resp.
  - On the dmem_resp edge:
    - dmem_read, dmem_write and dmem_byte_enable go to 0; return to IDLE.
    - out_regs<=in_regs; misalign<=0.
    - For loads, out_rdata<=ext(dmem_rdata >> 8*off): lb sign-extends bits [7:0], lbu zero-extends them; lh sign-extends [15:0], lhu zero-extends them; lw takes the whole word.
    - For stores, out_rdata<=0.
- Latency: a legal memory op occupies 1+k cycles, where k>=1 is the number of WAIT cycles up to and including the dmem_resp cycle. The earliest dmem_resp is the first WAIT cycle.
- Holding rule: in_regs is held by stall_out during WAIT. The same instruction is never re-issued, because it is consumed on the dmem_resp edge and upstream advances on that same edge.
- dmem_resp while in IDLE is ignored.
- Reset in WAIT: the request is dropped and the FSM goes to IDLE. A dmem_resp arriving after reset is ignored.
- Only ctrl.load_regfile and ctrl.write are ever modified; all other stage_regs fields pass through unchanged.

Test Plan:
- Reset:
  - Stimulus: hold rst for 2 cycles with arbitrary inputs.
  - Response: out_regs.valid=0, all dmem_* outputs 0, stall_out=0, misalign=0.
- lw with multi-cycle response:
  - Stimulus: lw with alu=0x100; dmem_resp arrives in the 3rd WAIT cycle with rdata=0xDEADBEEF.
  - Response: dmem_addr=0x100, byte_enable=1111, dmem_read high for 3 cycles, stall_out high for 3 cycles then low on the resp cycle, out_rdata=0xDEADBEEF, out_regs.valid=1.
- Load extension, rdata=0x80FF1234:
  - lb at 0x103 -> 0xFFFFFF80.
  - lbu at 0x103 -> 0x00000080.
  - lh at 0x102 -> 0xFFFF80FF.
  - lhu at 0x102 -> 0x000080FF.
  - lb at 0x100 -> 0x00000034.
- Store lanes:
  - sb at alu=0x101, rs2=0x000000AB -> addr=0x100, be=0010, wdata=0x0000AB00.
  - sh at 0x102, rs2=0x00001234 -> be=1100, wdata=0x12340000.
  - sw at 0x104 -> be=1111, wdata=rs2.
- Misaligned access:
  - Stimulus: sw at 0x102, then lh at 0x101.
  - Response: no dmem_read or dmem_write, stall_out=0, misalign=1 for each, out_regs.ctrl.load_regfile=0 and ctrl.write=0.
- Back-to-back ops and reset mid-WAIT:
  - ALU op -> lw -> ALU op: the ALU ops pass with zero stall.
  - Assert rst during WAIT, then pulse dmem_resp: the late resp is ignored, the FSM stays in IDLE, and the next ALU op passes through.
